// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: default geometry
// and the encoding of the post-reset clear sequencer.
package regfile_pkg;

    localparam int RF_DATA_W = 32;
    localparam int RF_DEPTH  = 32;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } rf_state_e;

endpackage

// File: rtl/regfile_mp_bypass.sv
// Per-read-port write bypass: picks the data of the highest-indexed write
// port that targets the read address, falling back to the stored word.
module regfile_mp_bypass
    import regfile_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int AW     = 5,
    parameter int NW     = 2
) (
    input  logic [AW-1:0]        raddr,
    input  logic [NW-1:0]        wvalid,
    input  logic [NW*AW-1:0]     waddr,
    input  logic [NW*DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0]    stored,
    output logic [DATA_W-1:0]    data,
    output logic                 hit
);

    // Priority mux: later (higher index) matches override earlier ones
    always_comb begin
        data = stored;
        hit  = 1'b0;
        for (int i = 0; i < NW; i++) begin
            if (wvalid[i] && (waddr[i*AW +: AW] == raddr)) begin
                data = wdata[i*DATA_W +: DATA_W];
                hit  = 1'b1;
            end else begin
                data = data;
                hit  = hit;
            end
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with same-cycle write bypass, a
// per-register busy scoreboard and a post-reset clear sweep so the storage
// array itself carries no reset.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int DEPTH    = RF_DEPTH,
    parameter int AW       = $clog2(DEPTH),
    parameter int NR       = 4,
    parameter int NW       = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 ready,
    input  logic [NW-1:0]        wen,
    input  logic [NW*AW-1:0]     waddr,
    input  logic [NW*DATA_W-1:0] wdata,
    input  logic [NR-1:0]        ren,
    input  logic [NR*AW-1:0]     raddr,
    output logic [NR*DATA_W-1:0] rdata,
    output logic [NR-1:0]        rbusy,
    input  logic                 set_busy_en,
    input  logic [AW-1:0]        set_busy_addr
);

    rf_state_e         state_r;
    rf_state_e         state_nxt_s;
    logic [AW:0]       ptr_r;
    logic [AW:0]       ptr_nxt_s;
    logic              ready_r;
    logic              clear_we_s;
    logic              run_s;
    logic [NW-1:0]     wvalid_s;
    logic              set_ok_s;
    logic [DEPTH-1:0]  busy_r;
    logic [DEPTH-1:0]  busy_nxt_s;
    logic [DATA_W-1:0] mem_r [DEPTH];

    // Sequencer state, clear pointer and ready flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_CLEAR;
            ptr_r   <= {(AW+1){1'b0}};
            ready_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            ptr_r   <= ptr_nxt_s;
            ready_r <= (state_nxt_s == ST_RUN);
        end
    end

    // Next state: sweep every entry once, leave CLEAR after the last one
    always_comb begin
        state_nxt_s = state_r;
        ptr_nxt_s   = ptr_r;
        case (state_r)
            ST_CLEAR: begin
                ptr_nxt_s = ptr_r + {{AW{1'b0}}, 1'b1};
                if (ptr_nxt_s[AW]) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_CLEAR;
                end
            end
            ST_RUN: begin
                state_nxt_s = ST_RUN;
            end
            default: begin
                state_nxt_s = ST_CLEAR;
                ptr_nxt_s   = {(AW+1){1'b0}};
            end
        endcase
    end

    // Sequencer outputs: clear-write strobe and normal-operation enable
    always_comb begin
        clear_we_s = 1'b0;
        run_s      = 1'b0;
        case (state_r)
            ST_CLEAR: clear_we_s = 1'b1;
            ST_RUN:   run_s      = 1'b1;
            default: begin
                clear_we_s = 1'b0;
                run_s      = 1'b0;
            end
        endcase
    end

    // Write qualification: traffic only in RUN, entry 0 read-only if hardwired
    always_comb begin
        wvalid_s = {NW{1'b0}};
        for (int i = 0; i < NW; i++) begin
            wvalid_s[i] = wen[i] & run_s &
                          ((ZERO_REG == 0) || (waddr[i*AW +: AW] != {AW{1'b0}}));
        end
        set_ok_s = set_busy_en & run_s &
                   ((ZERO_REG == 0) || (set_busy_addr != {AW{1'b0}}));
    end

    // Storage array: clear sweep, then writes with the highest port landing last
    always_ff @(posedge clk) begin
        if (clear_we_s) begin
            mem_r[ptr_r[AW-1:0]] <= {DATA_W{1'b0}};
        end else begin
            for (int i = 0; i < NW; i++) begin
                if (wvalid_s[i]) begin
                    mem_r[waddr[i*AW +: AW]] <= wdata[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Busy next value: writebacks clear, issue sets; set applied last so it wins
    always_comb begin
        busy_nxt_s = busy_r;
        for (int i = 0; i < NW; i++) begin
            if (wvalid_s[i]) begin
                busy_nxt_s[waddr[i*AW +: AW]] = 1'b0;
            end else begin
                busy_nxt_s = busy_nxt_s;
            end
        end
        if (set_ok_s) begin
            busy_nxt_s[set_busy_addr] = 1'b1;
        end else begin
            busy_nxt_s = busy_nxt_s;
        end
        if (ZERO_REG != 0) begin
            busy_nxt_s[0] = 1'b0;
        end else begin
            busy_nxt_s = busy_nxt_s;
        end
    end

    // Busy scoreboard register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_r <= {DEPTH{1'b0}};
        end else begin
            busy_r <= busy_nxt_s;
        end
    end

    assign ready = ready_r;

    for (genvar r = 0; r < NR; r++) begin : g_rd
        logic [AW-1:0]     ra_s;
        logic [DATA_W-1:0] byp_data_s;
        logic              byp_hit_s;
        logic              read_ok_s;
        logic              set_hit_s;
        logic [DATA_W-1:0] rd_s;
        logic              rb_s;

        assign ra_s = raddr[r*AW +: AW];

        regfile_mp_bypass #(
            .DATA_W (DATA_W),
            .AW     (AW),
            .NW     (NW)
        ) u_bypass (
            .raddr  (ra_s),
            .wvalid (wvalid_s),
            .waddr  (waddr),
            .wdata  (wdata),
            .stored (mem_r[ra_s]),
            .data   (byp_data_s),
            .hit    (byp_hit_s)
        );

        // Read port output: gated to zero when disabled, not ready or reading x0
        always_comb begin
            read_ok_s = ren[r] & ready_r &
                        !((ZERO_REG != 0) && (ra_s == {AW{1'b0}}));
            set_hit_s = set_ok_s & (set_busy_addr == ra_s);
            if (read_ok_s) begin
                rd_s = byp_data_s;
                if (byp_hit_s && !set_hit_s) begin
                    rb_s = 1'b0;
                end else begin
                    rb_s = busy_r[ra_s];
                end
            end else begin
                rd_s = {DATA_W{1'b0}};
                rb_s = 1'b0;
            end
        end

        assign rdata[r*DATA_W +: DATA_W] = rd_s;
        assign rbusy[r]                  = rb_s;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp. Stimulus queues hand-computed expectations
// tagged with the cycle they apply to; a monitor pops and compares them.
module tb_regfile_mp;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 32;
    localparam int AW     = 5;
    localparam int NR     = 4;
    localparam int NW     = 2;

    localparam int K_READY = 0;
    localparam int K_RDATA = 1;
    localparam int K_RBUSY = 2;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 ready;
    logic [NW-1:0]        wen = '0;
    logic [NW*AW-1:0]     waddr = '0;
    logic [NW*DATA_W-1:0] wdata = '0;
    logic [NR-1:0]        ren = '1;
    logic [NR*AW-1:0]     raddr = '0;
    logic [NR*DATA_W-1:0] rdata;
    logic [NR-1:0]        rbusy;
    logic                 set_busy_en = 1'b0;
    logic [AW-1:0]        set_busy_addr = '0;

    typedef struct {
        int          cyc;
        int          kind;
        int          port;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    regfile_mp #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .AW       (AW),
        .NR       (NR),
        .NW       (NW),
        .ZERO_REG (1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ready         (ready),
        .wen           (wen),
        .waddr         (waddr),
        .wdata         (wdata),
        .ren           (ren),
        .raddr         (raddr),
        .rdata         (rdata),
        .rbusy         (rbusy),
        .set_busy_en   (set_busy_en),
        .set_busy_addr (set_busy_addr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic expect_val(input int kind, input int port, input logic [31:0] e, input string nm);
        exp_t x;
        x.cyc  = cyc;
        x.kind = kind;
        x.port = port;
        x.exp  = e;
        x.name = nm;
        q.push_back(x);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        wen         = '0;
        set_busy_en = 1'b0;
        ren         = '1;
    endtask

    task automatic set_w(input int p, input int a, input logic [31:0] d);
        logic [AW-1:0] a5;
        a5 = a[AW-1:0];
        wen[p] = 1'b1;
        waddr[p*AW +: AW] = a5;
        wdata[p*DATA_W +: DATA_W] = d;
    endtask

    task automatic set_r(input int p, input int a);
        logic [AW-1:0] a5;
        a5 = a[AW-1:0];
        raddr[p*AW +: AW] = a5;
    endtask

    task automatic set_busy(input int a);
        set_busy_en   = 1'b1;
        set_busy_addr = a[AW-1:0];
    endtask

    // Release reset now and follow the clear sweep; optionally re-assert
    // reset in sweep cycle abort_at.
    task automatic sweep(input int abort_at);
        rst = 1'b1;
        expect_val(K_READY, 0, 32'd0, "ready_k0");
        for (int k = 1; k <= DEPTH; k++) begin
            next_cycle();
            if (k == abort_at) begin
                rst = 1'b0;
                expect_val(K_READY, 0, 32'd0, "ready_abort");
                return;
            end
            if (k == 5) begin
                set_w(0, 3, 32'hAAAA5555);
                set_busy(3);
                set_r(0, 3);
                expect_val(K_RDATA, 0, 32'd0, "clear_no_bypass");
            end
            expect_val(K_READY, 0, (k == DEPTH) ? 32'd1 : 32'd0, "ready_sweep");
        end
    endtask

    // Monitor: compare every expectation queued for the current cycle
    initial begin
        exp_t        x;
        logic [31:0] act;
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                x = q.pop_front();
                case (x.kind)
                    K_READY: act = {31'd0, ready};
                    K_RDATA: act = rdata[x.port*DATA_W +: DATA_W];
                    default: act = {31'd0, rbusy[x.port]};
                endcase
                checks++;
                if (x.cyc != cyc || act !== x.exp) begin
                    errors++;
                    $display("FAIL %s cyc %0d port %0d got %h expected %h",
                             x.name, x.cyc, x.port, act, x.exp);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout, CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        // In reset: outputs forced to zero
        repeat (3) @(posedge clk);
        #1;
        set_r(0, 1);
        expect_val(K_READY, 0, 32'd0, "ready_in_reset");
        expect_val(K_RDATA, 0, 32'd0, "rdata_in_reset");
        expect_val(K_RBUSY, 0, 32'd0, "rbusy_in_reset");
        next_cycle();
        sweep(0);

        // Every entry reads zero after the sweep; x3 untouched by CLEAR pulse
        for (int g = 0; g < DEPTH / NR; g++) begin
            next_cycle();
            for (int p = 0; p < NR; p++) begin
                set_r(p, g * NR + p);
                expect_val(K_RDATA, p, 32'd0, "clear_read");
            end
            if (g == 0) expect_val(K_RBUSY, 3, 32'd0, "clear_busy_x3");
        end

        // Bypass then storage read of x5
        next_cycle();
        set_w(0, 5, 32'hDEADBEEF);
        set_r(2, 5);
        expect_val(K_RDATA, 2, 32'hDEADBEEF, "bypass_x5");
        next_cycle();
        expect_val(K_RDATA, 2, 32'hDEADBEEF, "stored_x5");
        next_cycle();
        ren[2] = 1'b0;
        expect_val(K_RDATA, 2, 32'd0, "ren_off");

        // Two ports to x7: higher index wins
        next_cycle();
        set_w(0, 7, 32'h11111111);
        set_w(1, 7, 32'h22222222);
        set_r(0, 7);
        expect_val(K_RDATA, 0, 32'h22222222, "dual_bypass_x7");
        next_cycle();
        expect_val(K_RDATA, 0, 32'h22222222, "dual_stored_x7");

        // x0 hardwired
        next_cycle();
        set_w(0, 0, 32'hFFFFFFFF);
        set_busy(0);
        set_r(1, 0);
        expect_val(K_RDATA, 1, 32'd0, "x0_bypass");
        expect_val(K_RBUSY, 1, 32'd0, "x0_busy_same");
        next_cycle();
        expect_val(K_RDATA, 1, 32'd0, "x0_stored");
        expect_val(K_RBUSY, 1, 32'd0, "x0_busy_next");

        // Busy scoreboard on x9
        next_cycle();
        set_busy(9);
        set_r(3, 9);
        expect_val(K_RBUSY, 3, 32'd0, "busy_latency");
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            expect_val(K_RBUSY, 3, 32'd1, "busy_held");
        end
        next_cycle();
        set_w(1, 9, 32'h00001234);
        expect_val(K_RDATA, 3, 32'h00001234, "wb_bypass_x9");
        expect_val(K_RBUSY, 3, 32'd0, "wb_busy_masked");
        next_cycle();
        expect_val(K_RDATA, 3, 32'h00001234, "wb_stored_x9");
        expect_val(K_RBUSY, 3, 32'd0, "wb_busy_cleared");
        next_cycle();
        set_busy(9);
        set_w(0, 9, 32'h00005678);
        expect_val(K_RDATA, 3, 32'h00005678, "setwb_bypass_x9");
        next_cycle();
        expect_val(K_RBUSY, 3, 32'd1, "set_beats_clear");
        expect_val(K_RDATA, 3, 32'h00005678, "setwb_stored_x9");

        // Reset mid-sweep restarts the full clear
        next_cycle();
        rst = 1'b0;
        expect_val(K_READY, 0, 32'd0, "ready_rst_async");
        expect_val(K_RDATA, 3, 32'd0, "rdata_rst_async");
        expect_val(K_RBUSY, 3, 32'd0, "rbusy_rst_async");
        next_cycle();
        sweep(10);
        next_cycle();
        expect_val(K_READY, 0, 32'd0, "ready_held_rst");
        next_cycle();
        sweep(0);

        // Contents and busy wiped by the second sweep
        next_cycle();
        set_r(0, 5);
        set_r(1, 7);
        set_r(2, 9);
        set_r(3, 3);
        expect_val(K_RDATA, 0, 32'd0, "wiped_x5");
        expect_val(K_RDATA, 1, 32'd0, "wiped_x7");
        expect_val(K_RDATA, 2, 32'd0, "wiped_x9");
        expect_val(K_RDATA, 3, 32'd0, "wiped_x3");
        expect_val(K_RBUSY, 2, 32'd0, "wiped_busy_x9");

        repeat (2) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain got %0d expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port integer register file, successor to the 2R1W back-end regfile, for dual-issue back-end work.
- NR read ports and NW write ports, each with same-cycle write-to-read bypass.
- Per-register busy scoreboard for issue stalls.
- Post-reset clear FSM, so the storage array needs no reset; the block raises ready once every entry reads zero.
- Sits between decode/issue (reads, busy set) and writeback (writes).

Parameters:
DATA_W, 32, register width in bits
DEPTH, 32, number of architectural registers (power of two, >= 4)
AW, $clog2(DEPTH), register address width
NR, 4, number of read ports
NW, 2, number of write ports
ZERO_REG, 1, 1: entry 0 is hardwired to zero and never busy

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
ready  output  1  high when the clear sweep is done and the block accepts traffic
wen  input  NW  write enable per write port
waddr  input  NW*AW  write address, port i at [i*AW +: AW]
wdata  input  NW*DATA_W  write data, port i at [i*DATA_W +: DATA_W]
ren  input  NR  read enable per read port
raddr  input  NR*AW  read address per port
rdata  output  NR*DATA_W  read data per port (combinational)
rbusy  output  NR  busy flag of the addressed register per read port (combinational)
set_busy_en  input  1  mark a destination register busy (issue)
set_busy_addr  input  AW  register to mark busy

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM goes to CLEAR; clear pointer goes to 0.
  - ready=0; all busy bits go to 0.
  - rdata=0 and rbusy=0 while in reset.
- FSM states: CLEAR, RUN.
  - CLEAR: writes 0 to entry ptr each cycle, then ptr++. After the entry DEPTH-1 write, go to RUN next cycle, so ready rises DEPTH cycles after rst deasserts.
  - In CLEAR: wen and set_busy_en are ignored; rdata=0 and rbusy=0.
  - RUN: terminal state; left only via reset. Reset asserted mid-CLEAR restarts the sweep at ptr=0.
- Write (RUN only): on a clock edge, each port i with wen[i]=1 and a non-zero address (non-zero required only when ZERO_REG=1) writes wdata[i] to entry waddr[i].
  - Two ports writing the same address: the higher port index wins.
- Read, combinational, per port r:
  - ren[r]=0, or !ready, or (ZERO_REG and raddr[r]==0): rdata=0.
  - Else, if any write port this cycle has wen=1 and a matching valid address: rdata = wdata of the highest such port index (bypass).
  - Else: rdata = the stored entry.
- Busy scoreboard: DEPTH flops, async reset to 0.
  - A write on a valid address clears that address's busy bit.
  - set_busy_en sets busy[set_busy_addr]. Set and clear on the same address in the same cycle: set wins, because the new producer is younger.
  - With ZERO_REG, busy[0] stays 0 permanently.
  - rbusy[r] = busy[raddr[r]] & ren[r] & ready.
  - A bypass hit forces rbusy[r]=0 for that cycle, unless set_busy targets the same address in that cycle.
- Latency: write visible via bypass in the same cycle and from storage on the next cycle; the busy update takes effect next cycle.
- All address arithmetic uses AW bits. ptr is AW+1 bits so the sweep end is detected without wrap aliasing.

Decomposition:
- Shared package (regfile_pkg): FSM state encoding (CLEAR/RUN) and the default DATA_W/DEPTH constants, reused with define.v.
- One natural sub-module: regfile_mp_bypass.
  - Inputs: one read address, all write ports, stored word.
  - Outputs: selected data and hit flag, via a highest-index-wins priority mux.
  - Instantiated NR times.

Test Plan:
- Reset release -> ready=0 for exactly 32 cycles and 1 at cycle 33; all 32 reads return 0x00000000; a wen pulse during CLEAR leaves the entry at 0 after ready.
- Write port0 x5=0xDEADBEEF, read x5 on port2 in the same cycle -> rdata2=0xDEADBEEF (bypass); next cycle, with wen low, it still returns 0xDEADBEEF.
- Ports0/1 both write x7 (0x11111111 / 0x22222222) -> same-cycle read and later read both return 0x22222222.
- Write x0=0xFFFFFFFF and set_busy x0 -> read x0 returns 0 and rbusy=0.
- set_busy x9, then 3 idle cycles -> rbusy=1; port1 writes x9=0x1234 -> same-cycle rbusy=0, rdata=0x1234; set_busy x9 plus a write to x9 in one cycle -> next cycle rbusy=1.
- Assert rst at clear cycle 10 -> ready stays 0, and after release ready rises exactly 32 cycles later.
